// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues sequential pcs to a one-cycle imem, holds on
// decode backpressure and restarts on redirects.
//
// state | meaning
// IDLE  | fetching disabled; an in-flight word may still drain
// RUN   | issuing one fetch per cycle unless held
// ERR   | misaligned redirect seen; waits for an aligned redirect
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            out_ready,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_stall,
  input  logic [XLEN-1:0] imem_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fetch_misaligned,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight_v;
  logic            misaligned_q;
  logic [XLEN-1:0] count_q;

  logic hold;
  logic issue;
  logic handshake;
  logic redirect_aligned;

  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
  assign hold             = inflight_v & ~out_ready & ~redirect_valid;
  assign issue            = (state == RUN) & ~hold & ~redirect_valid;
  assign handshake        = inflight_v & out_ready;

  assign imem_addr        = fetch_pc;
  assign imem_stall       = hold;
  assign out_valid        = inflight_v;
  assign out_instr        = imem_data;
  assign out_pc           = inflight_pc;
  assign fetch_misaligned = misaligned_q;
  assign fetch_count      = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      inflight_pc  <= '0;
      inflight_v   <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= '0;
    end else begin
      // A handshake in the same cycle as a redirect still counts.
      if (handshake) begin
        count_q <= count_q + 32'd1;
      end

      if (redirect_valid) begin
        inflight_v <= 1'b0;
        if (redirect_aligned) begin
          fetch_pc     <= redirect_pc;
          state        <= fetch_en ? RUN : IDLE;
          misaligned_q <= 1'b0;
        end else begin
          state        <= ERR;
          misaligned_q <= 1'b1;
        end
      end else begin
        if (issue) begin
          inflight_v  <= 1'b1;
          inflight_pc <= fetch_pc;
          fetch_pc    <= next_pc(fetch_pc);
        end else if (!hold) begin
          inflight_v <= 1'b0;
        end

        case (state)
          IDLE:    if (fetch_en)  state <= RUN;
          RUN:     if (!fetch_en) state <= IDLE;
          default: state <= state;
        endcase
      end
    end
  end

endmodule
